// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor built around a single fullAdder cell.
// Operands are processed LSB-first, one bit per clock, WIDTH+1 cycles per operation.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_SUB_OVERFLOW_EN;
// without it, overflow is tied to 0 and no overflow register is built.

// fullAdder: one-bit full adder cell, the only arithmetic element of the serial datapath.
module fullAdder (
  input  logic val1,
  input  logic val2,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = val1 ^ val2 ^ cin;
  assign cout = (val1 & val2) | (cin & (val1 ^ val2));

endmodule

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry;
  logic             cout_reg;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;
  logic             load;

  // Subtraction is done as A + ~B + 1, so the inverted operand and the
  // initial carry of 1 are prepared at load time.
  fullAdder fa (
    .val1 (a_reg[0]),
    .val2 (b_reg[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign load   = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = res_reg;
  assign cout   = cout_reg;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE, so requests while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands at load, then shift one bit per SHIFT cycle with the sum entering the result MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      a_reg    <= val1;
      b_reg    <= sub ? ~val2 : val2;
      res_reg  <= '0;
      carry    <= sub;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else if (state == SHIFT) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      res_reg <= {fa_sum, res_reg[WIDTH-1:1]};
      carry   <= fa_cout;
      cnt     <= cnt + 1'b1;
      if (last) cout_reg <= fa_cout;
    end
  end

`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  logic ovf_reg;

  // On the MSB step the carry register still holds the carry into the MSB, so overflow is its XOR with the carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (load) begin
      ovf_reg <= 1'b0;
    end else if ((state == SHIFT) && last) begin
      ovf_reg <= carry ^ fa_cout;
    end
  end

  assign overflow = ovf_reg;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub (WIDTH=8).
// Stimulus pushes the expected {result, cout, overflow}; the monitor pops and compares on each done pulse.
module tb_serial_add_sub;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  int checks;
  int failures;
  int done_count;
  logic [WIDTH+1:0] exp_q[$];

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .val1     (val1),
    .val2     (val2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", {22'd0, result, cout, overflow}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("scoreboard", {22'd0, result, cout, overflow}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Issue one operation, push its expectation and measure done latency and busy length in cycles.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                               input logic [WIDTH-1:0] er, input logic ec, input logic ev,
                               output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    @(negedge clk);
    val1  = a;
    val2  = b;
    sub   = s;
    start = 1'b1;
    exp_q.push_back({er, ec, ev & OVF_EN});
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) lat = n;
      if ((busy !== 1'b1) && (n > 1)) break;
    end
  endtask

  initial begin
    int lat;
    int bcyc;
    int dc;
    checks = 0;
    failures = 0;
    done_count = 0;
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    val1 = '0;
    val2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {27'd0, busy, done, cout, overflow, 1'b0}, 32'd0);
    checkOutput("reset_result", {24'd0, result}, 32'd0);
    rst = 1'b0;

    applyStimulus(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, lat, bcyc);
    checkOutput("latency_add", lat, 9);
    checkOutput("busy_cycles", bcyc, 9);
    repeat (2) @(negedge clk);
    checkOutput("result_held", {24'd0, result}, 32'h7F);

    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, lat, bcyc);
    applyStimulus(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, lat, bcyc);
    checkOutput("latency_sub", lat, 9);
    applyStimulus(8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, lat, bcyc);
    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, lat, bcyc);
    applyStimulus(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, lat, bcyc);

    // Starts during SHIFT and during DONE must be ignored.
    dc = done_count;
    @(negedge clk);
    val1 = 8'h01;
    val2 = 8'h02;
    sub = 1'b0;
    start = 1'b1;
    exp_q.push_back({8'h03, 1'b0, 1'b0});
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = 1'b0;
      if ((n == 3) || (n == 9)) begin
        val1 = 8'hAA;
        val2 = 8'h55;
        sub = 1'b1;
        start = 1'b1;
      end
    end
    checkOutput("ignored_start_dones", done_count - dc, 1);
    checkOutput("ignored_start_busy", {31'd0, busy}, 32'd0);

    // Reset during the 4th SHIFT cycle aborts the operation.
    dc = done_count;
    @(negedge clk);
    val1 = 8'h35;
    val2 = 8'h4A;
    sub = 1'b0;
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkOutput("midreset_flags", {28'd0, busy, done, cout, overflow}, 32'd0);
    checkOutput("midreset_result", {24'd0, result}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("midreset_no_done", done_count - dc, 0);

    applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, lat, bcyc);
    checkOutput("latency_after_reset", lat, 9);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
